uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter DW, default 8: data bits per frame.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 tick  input  1  one-cycle strobe per bit period, from the baud clock generator's tx domain.
REQ-006 req  input  NREQ  per-requester transmit request; level, held until ack.
REQ-007 data  input  NREQ*DW  requester i byte at bits [i*DW +: DW].
REQ-008 par_en  input  1  parity bit enable.
REQ-009 par_odd  input  1  1 = odd parity, 0 = even.
REQ-010 ack  output  NREQ  one-cycle pulse to the requester whose byte was latched.
REQ-011 gnt_id  output  clog2(NREQ)  index of the current/last granted requester.
REQ-012 busy  output  1  high from grant through the end of the stop bit.
REQ-013 txd  output  1  serial line; idle high.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; all transitions except reset occur only on cycles with tick=1.
REQ-015 In IDLE, on a tick with any req bit high, the block SHALL grant, latch data, par_en and par_odd, and enter START.
REQ-016 Arbitration SHALL be round-robin: search from (last_gnt+1) mod NREQ upward with wrap; last_gnt updates on every grant.
REQ-017 In the grant cycle, the block SHALL register ack[g]=1 (visible the next cycle, exactly one cycle wide) and gnt_id=g; ack SHALL never have more than one bit set.
REQ-018 txd SHALL be registered: 1 in IDLE, 0 in START, latched data LSB first in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-019 Each state except IDLE SHALL last exactly one tick period, and DATA SHALL last DW tick periods with a bit counter of width clog2(DW) that resets to 0 on DATA entry.
REQ-020 On leaving DATA, the FSM SHALL go to PARITY if the latched par_en=1, otherwise to STOP.
REQ-021 Parity SHALL be the XOR of the latched data, inverted when the latched par_odd=1.
REQ-022 On the tick ending STOP, the FSM SHALL go to START with a new grant if any req is high, giving back-to-back frames with no idle bit; otherwise it goes to IDLE.
REQ-023 busy SHALL be low only in IDLE.
REQ-024 A req deasserted before its grant SHALL be dropped without an ack.
REQ-025 Changes to req, data or parity inputs after the grant cycle SHALL NOT affect the frame in flight.
REQ-026 If tick is held high continuously, the block SHALL advance one bit per cycle.

Reset
REQ-027 On rst=1 the block SHALL set state=IDLE, txd=1, busy=0, ack=0, gnt_id=0, last_gnt=NREQ-1 and the bit counter to 0, effective the cycle after rst is sampled.
REQ-028 Reset mid-frame SHALL abort the frame; the following first post-reset grant SHALL favour requester 0.
REQ-029 Reset SHALL take priority over a simultaneous tick or req.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and the baud-related constants shared with the clock generator.
REQ-031 The round-robin arbiter SHALL be a separate sub-module rr_arb (inputs: req, last_gnt; outputs: valid, gnt index), purely combinational.
REQ-032 The FSM, data shift register, parity and ack logic SHALL reside in uart_tx_sched.

Verification
REQ-033 Single request: req=4'b0001, data[7:0]=8'hA5, par_en=0, tick every 16 cycles -> ack[0] pulses once; txd shows 0,1,0,1,0,0,1,0,1,1 (one bit per tick); busy falls after stop.
REQ-034 Contention: req=4'b1111 held and each requester re-raised after its ack -> grant order is 0,1,2,3,0 and frames are back-to-back with no idle bit.
REQ-035 Parity: data=8'h07, par_en=1 -> even parity bit is 1 with par_odd=0 and 0 with par_odd=1; the frame is 11 bits.
REQ-036 Input stability: data changed to 8'hFF one cycle after ack while transmitting 8'h3C -> txd still serializes 8'h3C.
REQ-037 Reset mid-frame: rst pulsed during DATA bit 3 -> next cycle txd=1, busy=0; with req=4'b1001 afterwards, requester 0 is granted first.
REQ-038 Dropped request: req[2] raised and lowered between ticks while IDLE -> no ack and txd stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and the baud constants
// that the baud clock generator and the transmit scheduler agree on.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD_HZ    = 115_200;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned BAUD_DIV   = CLK_HZ / BAUD_HZ;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: searches upward from last_gnt+1 with
// wrap-around and reports the first requester found.
module rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic            valid,
  output logic [IW-1:0]   gnt
);

  logic [IW-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // branch; otherwise the unassigned paths infer latches.
  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last_gnt) + k) % NREQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        gnt   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: round-robin grants a requester's byte on a
// baud tick and serializes start, data (LSB first), optional parity and stop.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = 8,
  localparam int unsigned IW   = $clog2(NREQ),
  localparam int unsigned CW   = $clog2(DW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  input  logic               par_en,
  input  logic               par_odd,
  output logic [NREQ-1:0]    ack,
  output logic [IW-1:0]      gnt_id,
  output logic               busy,
  output logic               txd
);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   last_gnt_q, last_gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            txd_q, txd_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;

  logic            arb_valid;
  logic [IW-1:0]   arb_gnt;
  logic [DW-1:0]   gnt_byte;
  logic            grant_now;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .valid    (arb_valid),
    .gnt      (arb_gnt)
  );

  assign gnt_byte = data[32'(arb_gnt)*DW +: DW];

  // txd_d is the line level of the state being entered, so txd_q lines up
  // with state_q one cycle after each tick.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    ack_d      = '0;
    busy_d     = busy_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    grant_now  = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: grant_now = arb_valid;
        ST_START: begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end
        ST_DATA: begin
          if (bit_cnt_q == CW'(DW - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            txd_d   = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
        ST_STOP: begin
          grant_now = arb_valid;
          state_d   = ST_IDLE;
          txd_d     = 1'b1;
          busy_d    = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A grant from IDLE or at the end of STOP starts the next frame with no
    // idle bit in between.
    if (grant_now) begin
      state_d    = ST_START;
      txd_d      = 1'b0;
      busy_d     = 1'b1;
      gnt_id_d   = arb_gnt;
      last_gnt_d = arb_gnt;
      ack_d      = NREQ'(1) << arb_gnt;
      shift_d    = gnt_byte;
      par_en_d   = par_en;
      par_bit_d  = (^gnt_byte) ^ par_odd;
    end
  end

  // NOTE: the reset here is synchronous: rst is sampled on the clock edge and
  // takes priority over tick and req in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      last_gnt_q <= IW'(NREQ - 1);
      gnt_id_q   <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      txd_q      <= txd_d;
    end
  end

  // NOTE: the frame datapath is left unreset; it is always loaded at grant
  // before any state that reads it.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_en_q  <= par_en_d;
    par_bit_q <= par_bit_d;
  end

  assign ack    = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign txd    = txd_q;

endmodule
